bpm_acq_sequencer: RTL and testbench

Trigger-driven acquisition controller for the 4-channel ADC peak detector. On an external trigger it waits a programmable delay, then drives the detector's input-valid strobe for a programmable window. It then waits for the detector's result, lets the detector's registered max/overflow outputs settle, and captures them into a result register with a one-cycle valid pulse. It sits between the timing/trigger logic and the peak detector, and owns all window timing for it.

---
 rtl/bpm_acq_sequencer_if.sv | 50 +++++
 rtl/bpm_acq_sequencer.sv | 157 +++++++++++++++
 tb/tb_bpm_acq_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpm_acq_sequencer_if.sv
// Bus bundle for bpm_acq_sequencer: trigger/config, detector handshake and result outputs.
// `define ACQ_TAG_EN adds the res_tag acquisition label.
interface bpm_acq_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             trig;
  logic             clr_err;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_win_len;
  logic             pk_result_valid;
  logic [63:0]      pk_max;
  logic [3:0]       pk_ovf;
  logic             win_valid;
  logic             busy;
  logic             res_valid;
  logic [63:0]      res_max;
  logic [3:0]       res_ovf;
  logic [7:0]       trig_miss_cnt;
  logic             timeout_err;
`ifdef ACQ_TAG_EN
  logic [15:0]      res_tag;

  modport master (
    input  enable, trig, clr_err, cfg_delay, cfg_win_len,
    input  pk_result_valid, pk_max, pk_ovf,
    output win_valid, busy, res_valid, res_max, res_ovf,
    output trig_miss_cnt, timeout_err, res_tag
  );
  modport slave (
    output enable, trig, clr_err, cfg_delay, cfg_win_len,
    output pk_result_valid, pk_max, pk_ovf,
    input  win_valid, busy, res_valid, res_max, res_ovf,
    input  trig_miss_cnt, timeout_err, res_tag
  );
`else
  modport master (
    input  enable, trig, clr_err, cfg_delay, cfg_win_len,
    input  pk_result_valid, pk_max, pk_ovf,
    output win_valid, busy, res_valid, res_max, res_ovf,
    output trig_miss_cnt, timeout_err
  );
  modport slave (
    output enable, trig, clr_err, cfg_delay, cfg_win_len,
    output pk_result_valid, pk_max, pk_ovf,
    input  win_valid, busy, res_valid, res_max, res_ovf,
    input  trig_miss_cnt, timeout_err
  );
`endif
endinterface

// File: rtl/bpm_acq_sequencer.sv
// Trigger -> delay -> detector input window -> wait for result -> settle -> capture.
// `define ACQ_TAG_EN adds a 16-bit acquisition tag (res_tag) aligned with res_valid.
module bpm_acq_sequencer #(
  parameter int CNT_W   = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  bpm_acq_sequencer_if.master bus
);
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_WINDOW,
    ST_WAIT_RES,
    ST_SETTLE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_dly_cnt;
  logic [CNT_W-1:0] r_win_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [SET_W-1:0] r_set_cnt;
  logic             r_pk_now;
  logic             r_pk_prev;
  logic             r_win_valid;
  logic             r_busy;
  logic             r_res_valid;
  logic [63:0]      r_res_max;
  logic [3:0]       r_res_ovf;
  logic [7:0]       r_miss_cnt;
  logic             r_timeout_err;
`ifdef ACQ_TAG_EN
  logic [15:0]      r_tag;
`endif

  logic [CNT_W-1:0] w_len;
  logic             w_rise;
  logic             w_miss;

  assign w_len  = (bus.cfg_win_len == '0) ? CNT_W'(1) : bus.cfg_win_len;
  assign w_rise = r_pk_now & ~r_pk_prev;
  // r_busy also covers the res_valid cycle, so a trigger there is a miss.
  assign w_miss = bus.trig & r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_dly_cnt     <= '0;
      r_win_cnt     <= '0;
      r_to_cnt      <= '0;
      r_set_cnt     <= '0;
      r_pk_now      <= 1'b0;
      r_pk_prev     <= 1'b0;
      r_win_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_max     <= '0;
      r_res_ovf     <= '0;
      r_miss_cnt    <= '0;
      r_timeout_err <= 1'b0;
`ifdef ACQ_TAG_EN
      r_tag         <= '0;
`endif
    end else begin
      r_pk_now    <= bus.pk_result_valid;
      r_pk_prev   <= r_pk_now;
      r_res_valid <= 1'b0;

      if (bus.clr_err) begin
        r_miss_cnt <= '0;
      end else if (w_miss && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (bus.trig && bus.enable && !r_busy) begin
            r_busy    <= 1'b1;
            r_win_cnt <= w_len;
            if (bus.cfg_delay == '0) begin
              r_win_valid <= 1'b1;
              r_state     <= ST_WINDOW;
            end else begin
              r_dly_cnt <= bus.cfg_delay;
              r_state   <= ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          if (r_dly_cnt == CNT_W'(1)) begin
            r_win_valid <= 1'b1;
            r_state     <= ST_WINDOW;
          end else begin
            r_dly_cnt <= r_dly_cnt - CNT_W'(1);
          end
        end
        ST_WINDOW: begin
          if (r_win_cnt == CNT_W'(1)) begin
            r_win_valid <= 1'b0;
            r_to_cnt    <= '0;
            r_state     <= ST_WAIT_RES;
          end else begin
            r_win_cnt <= r_win_cnt - CNT_W'(1);
          end
        end
        ST_WAIT_RES: begin
          if (w_rise) begin
            r_set_cnt <= '0;
            r_state   <= ST_SETTLE;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_set_cnt == SET_W'(SETTLE - 1)) begin
            r_res_max   <= bus.pk_max;
            r_res_ovf   <= bus.pk_ovf;
            r_res_valid <= 1'b1;
`ifdef ACQ_TAG_EN
            r_tag       <= r_tag + 16'd1;
`endif
            r_state     <= ST_IDLE;
          end else begin
            r_set_cnt <= r_set_cnt + SET_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (bus.clr_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bus.win_valid     = r_win_valid;
  assign bus.busy          = r_busy;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_max       = r_res_max;
  assign bus.res_ovf       = r_res_ovf;
  assign bus.trig_miss_cnt = r_miss_cnt;
  assign bus.timeout_err   = r_timeout_err;
`ifdef ACQ_TAG_EN
  assign bus.res_tag       = r_tag;
`endif

endmodule

// File: tb/tb_bpm_acq_sequencer.sv
// Self-checking bench for bpm_acq_sequencer: schedule-based reference model plus directed literal checks.
module tb_bpm_acq_sequencer;
  localparam int CNT_W   = 16;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 64;
  localparam int LOGN    = 8192;
  localparam logic [63:0] FIX_MAX = 64'h7FFF_0010_7FFF_0020;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = -1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bpm_acq_sequencer_if #(.CNT_W(CNT_W)) w();

  bpm_acq_sequencer #(.CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        wv_log  [LOGN];
  logic        rv_log  [LOGN];
  logic [63:0] pkm_log [LOGN];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int count_hi(input bit sel_rv, input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if ((sel_rv ? rv_log[i] : wv_log[i]) === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_hi(input bit sel_rv, input int a, input int b);
    for (int i = a; i <= b; i++) if ((sel_rv ? rv_log[i] : wv_log[i]) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int last_hi(input bit sel_rv, input int a, input int b);
    for (int i = b; i >= a; i--) if ((sel_rv ? rv_log[i] : wv_log[i]) === 1'b1) return i;
    return -1;
  endfunction

  // Detector stand-in: drops result flag at window start, raises it 'lat' cycles after window end.
  int det_lat   = 2;
  bit det_fixed = 1'b0;
  bit det_rand  = 1'b0;

  initial begin : detector
    bit prev;
    int cnt;
    int lat;
    prev = 1'b0;
    cnt  = -1;
    w.pk_result_valid = 1'b0;
    w.pk_max = '0;
    w.pk_ovf = '0;
    forever begin
      @(posedge clk);
      #1;
      if (det_fixed) begin
        w.pk_max = FIX_MAX;
        w.pk_ovf = 4'b0101;
      end else begin
        w.pk_max = {$urandom, $urandom};
        w.pk_ovf = 4'($urandom);
      end
      if (w.win_valid && !prev) begin
        w.pk_result_valid = 1'b0;
        cnt = -1;
      end else if (!w.win_valid && prev) begin
        if (det_rand) lat = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
        else          lat = det_lat;
        if (lat == 0) w.pk_result_valid = 1'b1;
        else          cnt = lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          w.pk_result_valid = 1'b1;
          cnt = -1;
        end
      end
      prev = w.win_valid;
    end
  end

  // Reference model: each accepted trigger fixes a schedule of cycle numbers.
  bit          m_act  = 1'b0;
  int          m_ws   = 0;
  int          m_we   = 0;
  int          m_w0   = 0;
  int          m_det  = -1;
  logic [63:0] m_max  = '0;
  logic [3:0]  m_ovf  = '0;
  int          m_miss = 0;
  bit          m_terr = 1'b0;
  logic [15:0] m_tag  = '0;
  bit          h1 = 1'b0;
  bit          h2 = 1'b0;

  always @(negedge clk) begin : compare
    int  c;
    bit  busy_now;
    int  len;
    c = cyc;
    if (c >= 0 && c < LOGN) begin
      wv_log[c]  = w.win_valid;
      rv_log[c]  = w.res_valid;
      pkm_log[c] = w.pk_max;
    end
    if (!rst_n) begin
      chk("rst_outputs", 64'({w.win_valid, w.busy, w.res_valid, w.res_ovf, w.trig_miss_cnt, w.timeout_err}), 64'd0);
      chk("rst_res_max", w.res_max, 64'd0);
      m_act = 1'b0; m_det = -1; m_max = '0; m_ovf = '0;
      m_miss = 0; m_terr = 1'b0; m_tag = '0; h1 = 1'b0; h2 = 1'b0;
    end else if (c >= 0) begin
      chk("win_valid", 64'(w.win_valid), 64'(m_act && c >= m_ws && c <= m_we));
      chk("busy", 64'(w.busy), 64'(m_act));
      chk("res_valid", 64'(w.res_valid), 64'(m_act && m_det >= 0 && c == m_det + SETTLE + 1));
      chk("res_max", w.res_max, m_max);
      chk("res_ovf", 64'(w.res_ovf), 64'(m_ovf));
      chk("trig_miss_cnt", 64'(w.trig_miss_cnt), 64'(m_miss));
      chk("timeout_err", 64'(w.timeout_err), 64'(m_terr));
`ifdef ACQ_TAG_EN
      chk("res_tag", 64'(w.res_tag), 64'(m_tag));
`endif
      busy_now = m_act;
      if (m_act) begin
        if (m_det < 0 && c >= m_w0 && c <= m_w0 + TIMEOUT - 1) begin
          if (h1 && !h2) m_det = c;
          else if (c == m_w0 + TIMEOUT - 1) begin
            m_terr = 1'b1;
            m_act  = 1'b0;
          end
        end
        if (m_det >= 0 && c == m_det + SETTLE) begin
          m_max = w.pk_max;
          m_ovf = w.pk_ovf;
          m_tag = m_tag + 16'd1;
        end
        if (m_det >= 0 && c == m_det + SETTLE + 1) m_act = 1'b0;
      end
      if (w.trig) begin
        if (busy_now) begin
          if (m_miss < 255) m_miss++;
        end else if (w.enable) begin
          len   = (w.cfg_win_len == 0) ? 1 : int'(w.cfg_win_len);
          m_ws  = c + 1 + int'(w.cfg_delay);
          m_we  = m_ws + len - 1;
          m_w0  = m_we + 1;
          m_det = -1;
          m_act = 1'b1;
        end
      end
      if (w.clr_err) begin
        m_miss = 0;
        m_terr = 1'b0;
      end
      h2 = h1;
      h1 = w.pk_result_valid;
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trig(input int c, input int d, input int len);
    at_cycle(c);
    w.cfg_delay   = CNT_W'(d);
    w.cfg_win_len = CNT_W'(len);
    w.trig        = 1'b1;
    at_cycle(c + 1);
    w.trig        = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    w.enable = 1'b0;
    w.trig = 1'b0;
    w.clr_err = 1'b0;
    w.cfg_delay = '0;
    w.cfg_win_len = '0;

    at_cycle(2);
    chk("reset_state", 64'({w.win_valid, w.busy, w.res_valid, w.res_ovf, w.trig_miss_cnt, w.timeout_err}), 64'd0);
    at_cycle(3);
    rst_n = 1'b1;
    w.enable = 1'b1;

    // delay 5, length 10, trigger at 100
    det_lat = 2;
    pulse_trig(100, 5, 10);
    at_cycle(140);
    chk("t1_win_first", 64'(first_hi(0, 100, 139)), 64'd106);
    chk("t1_win_last", 64'(last_hi(0, 100, 139)), 64'd115);
    chk("t1_win_count", 64'(count_hi(0, 100, 139)), 64'd10);
    chk("t1_res_count", 64'(count_hi(1, 100, 139)), 64'd1);
    chk("t1_res_cycle", 64'(first_hi(1, 100, 139)), 64'd122);
    chk("t1_res_max", w.res_max, pkm_log[121]);

    // delay 0, length 0 -> one-cycle window right after the trigger
    det_lat = 1;
    pulse_trig(150, 0, 0);
    at_cycle(180);
    chk("t2_win_first", 64'(first_hi(0, 150, 179)), 64'd151);
    chk("t2_win_count", 64'(count_hi(0, 150, 179)), 64'd1);
    chk("t2_res_count", 64'(count_hi(1, 150, 179)), 64'd1);

    // three missed triggers, then clear
    det_lat = 3;
    pulse_trig(200, 3, 20);
    pulse_trig(205, 0, 1);
    pulse_trig(210, 0, 1);
    pulse_trig(215, 0, 1);
    at_cycle(217);
    chk("t3_miss_3", 64'(w.trig_miss_cnt), 64'd3);
    at_cycle(218);
    w.clr_err = 1'b1;
    at_cycle(219);
    w.clr_err = 1'b0;
    at_cycle(220);
    chk("t3_miss_clr", 64'(w.trig_miss_cnt), 64'd0);
    at_cycle(245);
    chk("t3_res_count", 64'(count_hi(1, 200, 244)), 64'd1);

    // 300 missed triggers saturate the counter
    det_lat = 2;
    pulse_trig(300, 400, 5);
    at_cycle(301);
    w.trig = 1'b1;
    at_cycle(601);
    w.trig = 1'b0;
    at_cycle(602);
    chk("t4_miss_sat", 64'(w.trig_miss_cnt), 64'd255);
    at_cycle(605);
    w.clr_err = 1'b1;
    at_cycle(606);
    w.clr_err = 1'b0;
    at_cycle(740);

    // detector never answers -> timeout after 64 cycles in wait
    det_lat = -1;
    pulse_trig(800, 2, 4);
    at_cycle(870);
    chk("t5_terr_before", 64'({w.timeout_err, w.busy}), 64'b01);
    at_cycle(871);
    chk("t5_terr_after", 64'({w.timeout_err, w.busy}), 64'b10);
    det_lat = 2;
    pulse_trig(880, 1, 2);
    at_cycle(900);
    chk("t5_no_res_on_timeout", 64'(count_hi(1, 800, 879)), 64'd0);
    chk("t5_res_after", 64'(count_hi(1, 880, 899)), 64'd1);
    chk("t5_terr_sticky", 64'(w.timeout_err), 64'd1);
    w.clr_err = 1'b1;
    at_cycle(901);
    w.clr_err = 1'b0;
    at_cycle(902);
    chk("t5_terr_clr", 64'(w.timeout_err), 64'd0);

    // asynchronous reset in the middle of a window
    pulse_trig(1000, 1, 30);
    at_cycle(1010);
    chk("t6_win_before_rst", 64'({w.win_valid, w.busy}), 64'b11);
    rst_n = 1'b0;
    #1;
    chk("t6_async_drop", 64'({w.win_valid, w.busy}), 64'b00);
    at_cycle(1013);
    rst_n = 1'b1;
    at_cycle(1090);
    chk("t6_no_res_after_rst", 64'(count_hi(1, 1011, 1089)), 64'd0);
    chk("t6_no_win_after_rst", 64'(count_hi(0, 1011, 1089)), 64'd0);

    // fixed detector values
    det_fixed = 1'b1;
    pulse_trig(1100, 2, 3);
    at_cycle(1111);
    chk("t7_res_max_pre", w.res_max, 64'd0);
`ifdef ACQ_TAG_EN
    chk("t7_tag_pre", 64'(w.res_tag), 64'd0);
`endif
    at_cycle(1112);
    chk("t7_res_valid", 64'(w.res_valid), 64'd1);
    chk("t7_res_max", w.res_max, 64'h7FFF_0010_7FFF_0020);
    chk("t7_res_ovf", 64'(w.res_ovf), 64'b0101);
`ifdef ACQ_TAG_EN
    chk("t7_tag", 64'(w.res_tag), 64'd1);
`endif
    at_cycle(1130);
    det_fixed = 1'b0;

    // randomized traffic, checked by the model every cycle
    det_rand = 1'b1;
    for (int c = 1200; c < 5000; c++) begin
      at_cycle(c);
      w.trig        = ($urandom_range(0, 7) == 0);
      w.enable      = ($urandom_range(0, 9) != 0);
      w.clr_err     = ($urandom_range(0, 63) == 0);
      w.cfg_delay   = CNT_W'($urandom_range(0, 6));
      w.cfg_win_len = CNT_W'($urandom_range(0, 5));
    end
    at_cycle(5000);
    w.trig = 1'b0;
    w.clr_err = 1'b0;
    at_cycle(5100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
